// File: rtl/pc_sequencer.sv
// Program counter sequencer: owns the fetch PC, selects the next PC by
// redirect / return-stack pop / sequential increment, with boot, halt and stall.
module pc_sequencer #(
  parameter int                WIDTH        = 32,
  parameter int                INC          = 4,
  parameter logic [WIDTH-1:0]  RESET_VECTOR = '0,
  parameter int                RAS_DEPTH    = 4
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Stall,
  input  logic              Redirect,
  input  logic [WIDTH-1:0]  RedirectTarget,
  input  logic              Call,
  input  logic              Ret,
  input  logic              Halt,
  input  logic              Resume,
  output logic [WIDTH-1:0]  PCResult,
  output logic [WIDTH-1:0]  PCAddResult,
  output logic              PCValid,
  output logic              RasEmpty,
  output logic              RasFull,
  output logic              RasOverflow,
  output logic              RasUnderflow,
  output logic              Misaligned
);

  localparam int               PTR_W      = $clog2(RAS_DEPTH);
  localparam int               CNT_W      = PTR_W + 1;
  localparam logic [WIDTH-1:0] INC_W      = WIDTH'(INC);
  localparam logic [WIDTH-1:0] ALIGN_MASK = INC_W - WIDTH'(1);
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(RAS_DEPTH);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] ras [RAS_DEPTH];
  logic [PTR_W-1:0] ras_ptr;
  logic [CNT_W-1:0] ras_count;
  logic [PTR_W-1:0] top_idx;

  // ras_ptr names the next slot to write; wrapping it makes a full push
  // overwrite the oldest entry.
  assign top_idx     = ras_ptr - PTR_W'(1);
  assign PCAddResult = PCResult + INC_W;
  assign PCValid     = (state == RUN);
  assign RasEmpty    = (ras_count == '0);
  assign RasFull     = (ras_count == FULL_COUNT);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state        <= BOOT;
      PCResult     <= RESET_VECTOR;
      ras_ptr      <= '0;
      ras_count    <= '0;
      RasOverflow  <= 1'b0;
      RasUnderflow <= 1'b0;
      Misaligned   <= 1'b0;
      for (int i = 0; i < RAS_DEPTH; i++) begin
        ras[i] <= '0;
      end
    end else begin
      Misaligned <= 1'b0;
      unique case (state)
        BOOT: state <= RUN;
        RUN: begin
          // Redirect is a flush and therefore wins over Stall.
          if (Redirect) begin
            PCResult   <= RedirectTarget & ~ALIGN_MASK;
            Misaligned <= |(RedirectTarget & ALIGN_MASK);
            if (Call) begin
              ras[ras_ptr] <= PCAddResult;
              ras_ptr      <= ras_ptr + PTR_W'(1);
              if (RasFull) begin
                RasOverflow <= 1'b1;
              end else begin
                ras_count <= ras_count + CNT_W'(1);
              end
            end
          end else if (!Stall) begin
            if (Halt) begin
              state <= HALT;
            end else if (Ret && !RasEmpty) begin
              PCResult  <= ras[top_idx];
              ras_ptr   <= top_idx;
              ras_count <= ras_count - CNT_W'(1);
            end else begin
              if (Ret) begin
                RasUnderflow <= 1'b1;
              end
              PCResult <= PCAddResult;
            end
          end
        end
        HALT: begin
          if (Resume) begin
            state <= RUN;
          end
        end
        default: state <= BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed vector table, hand-written corner sequences,
// a 16-bit wrap instance and random traffic against a queue-based model.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, stall, redirect, call, ret, halt, resume;
  logic [31:0] target;
  logic [31:0] pc, pc_add;
  logic        valid, empty, full, ovf, unf, mis;

  logic        rst16, redirect16;
  logic [15:0] target16, pc16, pc_add16;
  logic        valid16, empty16, full16, ovf16, unf16, mis16;

  pc_sequencer #(
    .WIDTH(32), .INC(4), .RESET_VECTOR(32'h0000_1000), .RAS_DEPTH(4)
  ) dut (
    .Clk(clk), .Reset(rst_n), .Stall(stall), .Redirect(redirect),
    .RedirectTarget(target), .Call(call), .Ret(ret), .Halt(halt),
    .Resume(resume), .PCResult(pc), .PCAddResult(pc_add), .PCValid(valid),
    .RasEmpty(empty), .RasFull(full), .RasOverflow(ovf),
    .RasUnderflow(unf), .Misaligned(mis)
  );

  pc_sequencer #(
    .WIDTH(16), .INC(4), .RESET_VECTOR(16'h0000), .RAS_DEPTH(4)
  ) dut16 (
    .Clk(clk), .Reset(rst16), .Stall(1'b0), .Redirect(redirect16),
    .RedirectTarget(target16), .Call(1'b0), .Ret(1'b0), .Halt(1'b0),
    .Resume(1'b0), .PCResult(pc16), .PCAddResult(pc_add16), .PCValid(valid16),
    .RasEmpty(empty16), .RasFull(full16), .RasOverflow(ovf16),
    .RasUnderflow(unf16), .Misaligned(mis16)
  );

  typedef struct {
    string       name;
    logic        stall, redirect;
    logic [31:0] target;
    logic        call, ret, halt, resume;
    logic [31:0] exp_pc;
    logic        exp_valid, exp_empty, exp_full, exp_ovf, exp_unf, exp_mis;
  } vec_t;

  vec_t tbl[$];
  int   total = 0;
  int   bad   = 0;

  // Behavioural model state: a plain queue stands in for the return stack.
  logic        m_booted, m_halted, m_ovf, m_unf, m_mis;
  logic [31:0] m_pc;
  logic [31:0] m_ras[$];

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s actual=%h required=%h", name, actual, expected);
    end
  endtask

  task automatic check_output(input string tag, input logic [31:0] e_pc, input logic e_valid,
                              input logic e_empty, input logic e_full, input logic e_ovf,
                              input logic e_unf, input logic e_mis);
    check({tag, ".pc"}, pc, e_pc);
    check({tag, ".pc_add"}, pc_add, e_pc + 32'd4);
    check({tag, ".valid"}, 32'(valid), 32'(e_valid));
    check({tag, ".empty"}, 32'(empty), 32'(e_empty));
    check({tag, ".full"}, 32'(full), 32'(e_full));
    check({tag, ".ovf"}, 32'(ovf), 32'(e_ovf));
    check({tag, ".unf"}, 32'(unf), 32'(e_unf));
    check({tag, ".mis"}, 32'(mis), 32'(e_mis));
  endtask

  task automatic apply_stimulus(input logic s, input logic r, input logic [31:0] t,
                                input logic c, input logic rt, input logic h, input logic rs);
    stall = s; redirect = r; target = t; call = c; ret = rt; halt = h; resume = rs;
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic void add(input string n, input logic s, input logic r, input logic [31:0] t,
                              input logic c, input logic rt, input logic h, input logic rs,
                              input logic [31:0] p, input logic v, input logic e, input logic f,
                              input logic o, input logic u, input logic m);
    vec_t x;
    x.name = n; x.stall = s; x.redirect = r; x.target = t; x.call = c; x.ret = rt;
    x.halt = h; x.resume = rs; x.exp_pc = p; x.exp_valid = v; x.exp_empty = e;
    x.exp_full = f; x.exp_ovf = o; x.exp_unf = u; x.exp_mis = m;
    tbl.push_back(x);
  endfunction

  // Model step: applies the priority rules to the model for one clock edge.
  task automatic model_step(input logic s, input logic r, input logic [31:0] t,
                            input logic c, input logic rt, input logic h, input logic rs);
    logic [31:0] link;
    link  = m_pc + 32'd4;
    m_mis = 1'b0;
    if (!m_booted) begin
      m_booted = 1'b1;
    end else if (m_halted) begin
      if (rs) m_halted = 1'b0;
    end else if (r) begin
      if (c) begin
        m_ras.push_back(link);
        if (m_ras.size() > 4) begin
          void'(m_ras.pop_front());
          m_ovf = 1'b1;
        end
      end
      m_pc  = {t[31:2], 2'b00};
      m_mis = (t[1:0] != 2'b00);
    end else if (s) begin
      m_pc = m_pc;
    end else if (h) begin
      m_halted = 1'b1;
    end else if (rt && m_ras.size() > 0) begin
      m_pc = m_ras.pop_back();
    end else begin
      if (rt) m_unf = 1'b1;
      m_pc = link;
    end
  endtask

  task automatic step16(input logic r, input logic [15:0] t);
    redirect16 = r; target16 = t;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; rst16 = 1'b0; redirect16 = 1'b0; target16 = '0;
    stall = 0; redirect = 0; target = '0; call = 0; ret = 0; halt = 0; resume = 0;

    //    name        stl rd target        cl rt ht rs  exp_pc        v  e  f  o  u  m
    add("boot",       0, 0, 32'h0,        0, 0, 0, 0, 32'h1000,     1, 1, 0, 0, 0, 0);
    add("seq1",       0, 0, 32'h0,        0, 0, 0, 0, 32'h1004,     1, 1, 0, 0, 0, 0);
    add("seq2",       0, 0, 32'h0,        0, 0, 0, 0, 32'h1008,     1, 1, 0, 0, 0, 0);
    add("to2000",     0, 1, 32'h2000,     0, 0, 0, 0, 32'h2000,     1, 1, 0, 0, 0, 0);
    add("stall1",     1, 0, 32'h0,        0, 0, 1, 0, 32'h2000,     1, 1, 0, 0, 0, 0);
    add("stall2",     1, 0, 32'h0,        0, 1, 0, 0, 32'h2000,     1, 1, 0, 0, 0, 0);
    add("stall3",     1, 0, 32'h0,        0, 0, 0, 0, 32'h2000,     1, 1, 0, 0, 0, 0);
    add("stall_rd",   1, 1, 32'h3000,     0, 0, 0, 0, 32'h3000,     1, 1, 0, 0, 0, 0);
    add("to100",      0, 1, 32'h100,      0, 0, 0, 0, 32'h100,      1, 1, 0, 0, 0, 0);
    add("call800",    0, 1, 32'h800,      1, 1, 0, 0, 32'h800,      1, 0, 0, 0, 0, 0);
    add("ret1",       0, 0, 32'h0,        0, 1, 0, 0, 32'h104,      1, 1, 0, 0, 0, 0);
    add("ret_unf",    0, 0, 32'h0,        0, 1, 0, 0, 32'h108,      1, 1, 0, 0, 1, 0);
    add("to10",       0, 1, 32'h10,       0, 0, 0, 0, 32'h10,       1, 1, 0, 0, 1, 0);
    add("call_a",     0, 1, 32'h20,       1, 0, 0, 0, 32'h20,       1, 0, 0, 0, 1, 0);
    add("call_b",     0, 1, 32'h30,       1, 0, 0, 0, 32'h30,       1, 0, 0, 0, 1, 0);
    add("call_c",     0, 1, 32'h40,       1, 0, 0, 0, 32'h40,       1, 0, 0, 0, 1, 0);
    add("call_d",     0, 1, 32'h50,       1, 0, 0, 0, 32'h50,       1, 0, 1, 0, 1, 0);
    add("call_ovf",   0, 1, 32'h60,       1, 0, 0, 0, 32'h60,       1, 0, 1, 1, 1, 0);
    add("pop54",      0, 0, 32'h0,        0, 1, 0, 0, 32'h54,       1, 0, 0, 1, 1, 0);
    add("pop44",      0, 0, 32'h0,        0, 1, 0, 0, 32'h44,       1, 0, 0, 1, 1, 0);
    add("pop34",      0, 0, 32'h0,        0, 1, 0, 0, 32'h34,       1, 0, 0, 1, 1, 0);
    add("pop24",      0, 0, 32'h0,        0, 1, 0, 0, 32'h24,       1, 1, 0, 1, 1, 0);
    add("to_top",     0, 1, 32'hFFFF_FFFC, 0, 0, 0, 0, 32'hFFFF_FFFC, 1, 1, 0, 1, 1, 0);
    add("wrap",       0, 0, 32'h0,        0, 0, 0, 0, 32'h0,        1, 1, 0, 1, 1, 0);
    add("misalign",   0, 1, 32'h123,      0, 0, 0, 0, 32'h120,      1, 1, 0, 1, 1, 1);
    add("mis_clear",  0, 0, 32'h0,        0, 0, 0, 0, 32'h124,      1, 1, 0, 1, 1, 0);
    add("to40",       0, 1, 32'h40,       0, 0, 0, 0, 32'h40,       1, 1, 0, 1, 1, 0);
    add("halt",       0, 0, 32'h0,        0, 0, 1, 0, 32'h40,       0, 1, 0, 1, 1, 0);
    add("halt_rd",    0, 1, 32'h800,      1, 0, 0, 0, 32'h40,       0, 1, 0, 1, 1, 0);
    add("halt_ret",   0, 0, 32'h0,        0, 1, 0, 0, 32'h40,       0, 1, 0, 1, 1, 0);
    add("halt_both",  1, 1, 32'h900,      1, 1, 0, 0, 32'h40,       0, 1, 0, 1, 1, 0);
    add("halt_rd2",   0, 1, 32'h123,      0, 0, 0, 0, 32'h40,       0, 1, 0, 1, 1, 0);
    add("halt_idle",  0, 0, 32'h0,        0, 0, 1, 0, 32'h40,       0, 1, 0, 1, 1, 0);
    add("resume",     0, 0, 32'h0,        0, 0, 0, 1, 32'h40,       1, 1, 0, 1, 1, 0);
    add("post_res",   0, 0, 32'h0,        0, 0, 0, 0, 32'h44,       1, 1, 0, 1, 1, 0);
    add("call200",    0, 1, 32'h200,      1, 1, 0, 0, 32'h200,      1, 0, 0, 1, 1, 0);
    add("halt2",      0, 0, 32'h0,        0, 0, 1, 0, 32'h200,      0, 0, 0, 1, 1, 0);

    @(negedge clk);
    check_output("reset", 32'h1000, 0, 1, 0, 0, 0, 0);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      apply_stimulus(tbl[i].stall, tbl[i].redirect, tbl[i].target, tbl[i].call,
                     tbl[i].ret, tbl[i].halt, tbl[i].resume);
      check_output(tbl[i].name, tbl[i].exp_pc, tbl[i].exp_valid, tbl[i].exp_empty,
                   tbl[i].exp_full, tbl[i].exp_ovf, tbl[i].exp_unf, tbl[i].exp_mis);
    end

    // Asynchronous reset landing mid-cycle while halted with a live RAS entry.
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_output("async_rst", 32'h1000, 0, 1, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    apply_stimulus(0, 0, 32'h0, 0, 1, 0, 0);
    check_output("reboot", 32'h1000, 1, 1, 0, 0, 0, 0);
    apply_stimulus(0, 0, 32'h0, 0, 1, 0, 0);
    check_output("reboot_ret", 32'h1004, 1, 1, 0, 0, 1, 0);

    // 16-bit instance: increment wraps at the top of the address space.
    check("w16.reset_pc", 32'(pc16), 32'h0);
    check("w16.reset_valid", 32'(valid16), 32'h0);
    rst16 = 1'b1;
    step16(0, 16'h0);
    check("w16.boot_valid", 32'(valid16), 32'h1);
    step16(1, 16'hFFFC);
    check("w16.top_pc", 32'(pc16), 32'hFFFC);
    check("w16.top_add", 32'(pc_add16), 32'h0000);
    step16(0, 16'h0);
    check("w16.wrap_pc", 32'(pc16), 32'h0000);
    check("w16.wrap_ovf", 32'(ovf16), 32'h0);
    step16(1, 16'h0123);
    check("w16.mis_pc", 32'(pc16), 32'h0120);
    check("w16.mis_pulse", 32'(mis16), 32'h1);
    step16(0, 16'h0);
    check("w16.mis_clear", 32'(mis16), 32'h0);
    check("w16.after_pc", 32'(pc16), 32'h0124);

    // Random traffic against the model, starting from a fresh reset.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_booted = 0; m_halted = 0; m_ovf = 0; m_unf = 0; m_mis = 0;
    m_pc = 32'h1000; m_ras.delete();
    for (int n = 0; n < 600; n++) begin
      logic s, r, c, rt, h, rs;
      logic [31:0] t;
      s  = ($urandom_range(0, 5) == 0);
      r  = ($urandom_range(0, 5) == 0);
      c  = ($urandom_range(0, 1) == 0);
      rt = ($urandom_range(0, 3) == 0);
      h  = ($urandom_range(0, 19) == 0);
      rs = ($urandom_range(0, 2) == 0);
      t  = $urandom;
      apply_stimulus(s, r, t, c, rt, h, rs);
      model_step(s, r, t, c, rt, h, rs);
      check_output("rnd", m_pc, m_booted && !m_halted, m_ras.size() == 0,
                   m_ras.size() == 4, m_ovf, m_unf, m_mis);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Parametrised successor to the fixed +4 PC incrementor: owns the program counter register and produces both the PC and PC+INC.
- Selects next PC by priority: redirect (branch/jump), return-address-stack pop, sequential increment.
- Adds stall, halt/resume, a boot state and a small return-address stack (RAS) for call/return.
- Sits at the front of the fetch stage and drives instruction-memory address and the link value.

Parameters:
- WIDTH, 32, PC width in bits.
- INC, 4, sequential increment; power of two >= 1.
- RESET_VECTOR, 32'h0, PC value loaded by reset; must be INC-aligned.
- RAS_DEPTH, 4, return-address-stack entries; power of two >= 2.

Ports:
- Clk  in  1  rising-edge clock.
- Reset  in  1  asynchronous, active-low reset.
- Stall  in  1  hold PC and RAS this cycle.
- Redirect  in  1  load RedirectTarget as next PC.
- RedirectTarget  in  WIDTH  branch/jump target.
- Call  in  1  qualifies Redirect; push PCResult+INC onto RAS.
- Ret  in  1  pop RAS top as next PC.
- Halt  in  1  enter HALT.
- Resume  in  1  leave HALT.
- PCResult  out  WIDTH  current PC (registered).
- PCAddResult  out  WIDTH  PCResult+INC, combinational from PCResult.
- PCValid  out  1  PCResult is a live fetch address.
- RasEmpty  out  1  RAS holds no entries.
- RasFull  out  1  RAS holds RAS_DEPTH entries.
- RasOverflow  out  1  sticky: push occurred while full.
- RasUnderflow  out  1  sticky: Ret seen while empty.
- Misaligned  out  1  one-cycle pulse: accepted RedirectTarget not INC-aligned.

Behaviour:
- Reset asserted (Reset=0), async:
  - PCResult=RESET_VECTOR; PCAddResult=RESET_VECTOR+INC.
  - PCValid=0; RAS count=0, so RasEmpty=1 and RasFull=0.
  - Sticky flags=0; Misaligned=0; state=BOOT.
  - Reset mid-operation discards all RAS contents and any pending state.
- State machine:
  - BOOT: first edge after Reset deasserts goes to RUN. PC unchanged. PCValid=1 from that edge. All other inputs ignored in BOOT.
  - RUN: at each edge, evaluate in strict priority:
    1. Redirect=1, even if Stall=1 (flush overrides stall): PC<=RedirectTarget with low log2(INC) bits forced to 0. Misaligned pulses 1 next cycle if those bits were nonzero. If Call=1, push PCResult+INC. Ret is ignored.
    2. Stall=1: PC, RAS and state hold. Halt is ignored.
    3. Halt=1: state<=HALT; PC holds.
    4. Ret=1 and RAS not empty: PC<=top; pop.
    5. Ret=1 and RAS empty: RasUnderflow<=1; PC<=PCResult+INC.
    6. Otherwise: PC<=PCResult+INC.
  - HALT: PCValid=0 (combinational on state). PC and RAS hold. Redirect, Call, Ret and Stall are ignored. Resume=1 moves to RUN; PC advances normally from the following edge.
- Call without Redirect is ignored.
- Arithmetic:
  - All PC addition is modulo 2^WIDTH.
  - PC=2^WIDTH-INC increments to 0 with no flag.
  - RAS pushes store WIDTH bits.
- RAS:
  - Circular LIFO.
  - A push while full overwrites the oldest entry, count stays RAS_DEPTH, and RasOverflow<=1.
  - Pop returns the most recent surviving entries in LIFO order.
- Sticky flags clear only on reset.
- Latency: new PC visible on PCResult one clock after the selecting edge. PCAddResult follows PCResult combinationally.

Test Plan:
1. Reset (RESET_VECTOR=32'h0000_1000) -> PCResult=32'h1000, PCValid=0. After release, one BOOT edge keeps 32'h1000 with PCValid=1. Next edges give 32'h1004, then 32'h1008.
2. From PC=32'h2000: 3 cycles Stall=1 -> PC stays 32'h2000. Stall=1 with Redirect=1, target 32'h3000 -> PC=32'h3000 next cycle.
3. Calls/returns:
   - Call+Redirect at PC=32'h100 to 32'h800 -> PC=32'h800, RasEmpty=0.
   - Ret -> PC=32'h104. Second Ret -> RasUnderflow=1, PC=32'h108.
4. RAS_DEPTH=4: five Call+Redirect from PCs 0x10,0x20,0x30,0x40,0x50 -> RasFull=1, RasOverflow=1. Four Rets -> PCs 0x54,0x44,0x34,0x24, then RasEmpty=1.
5. WIDTH=16, PC=16'hFFFC -> next PC 16'h0000. Redirect to 16'h0123 -> PC=16'h0120, Misaligned pulses one cycle.
6. Halt at PC=32'h40 -> PCValid=0, PC holds 32'h40 across Redirect and Ret for 5 cycles. Resume -> RUN; next edge gives PC=32'h44. Reset asserted mid-HALT -> PC=RESET_VECTOR, RAS empty.
